// File: rtl/vram_arbiter_pkg.sv
// ============================================================================
// Module      : vram_arbiter_pkg
// Description : Shared display geometry, pixel type and grant-source encoding
//               for the VRAM arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vram_arbiter_pkg;

    localparam int PIXEL_W            = 16;
    localparam int DISPLAY_WIDTH_DEF  = 240;
    localparam int DISPLAY_HEIGHT_DEF = 320;
    localparam int VRAM_L_DEF         = DISPLAY_WIDTH_DEF * DISPLAY_HEIGHT_DEF;
    localparam int N_ADDR_DEF         = $clog2(VRAM_L_DEF);

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_DISP  = 2'd1,
        SRC_DRAW  = 2'd2,
        SRC_CLEAR = 2'd3
    } src_e;

    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] words);
        return addr < words;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vram_arbiter_if.sv
// ============================================================================
// Module      : vram_arbiter_if
// Description : Requester and RAM-side signals of the VRAM arbiter; slave is
//               the arbiter's view, master the requester/RAM view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vram_arbiter_if
    import vram_arbiter_pkg::*;
#(
    parameter int N_ADDR = N_ADDR_DEF
);

    logic              disp_rd_req;
    logic [N_ADDR-1:0] disp_rd_addr;
    logic              disp_rd_ready;
    logic              disp_rd_valid;
    pixel_t            disp_rd_data;

    logic              draw_valid;
    logic [N_ADDR-1:0] draw_addr;
    pixel_t            draw_data;
    logic              draw_ready;

    logic              clear_start;
    pixel_t            clear_color;
    logic              clear_busy;
    logic              clear_done;

    logic [N_ADDR-1:0] vram_addr;
    logic              vram_wr_ena;
    pixel_t            vram_wr_data;
    pixel_t            vram_rd_data;

    src_e              grant_src;

    modport slave (
        input  disp_rd_req, disp_rd_addr,
        input  draw_valid, draw_addr, draw_data,
        input  clear_start, clear_color,
        input  vram_rd_data,
        output disp_rd_ready, disp_rd_valid, disp_rd_data,
        output draw_ready,
        output clear_busy, clear_done,
        output vram_addr, vram_wr_ena, vram_wr_data,
        output grant_src
    );

    modport master (
        output disp_rd_req, disp_rd_addr,
        output draw_valid, draw_addr, draw_data,
        output clear_start, clear_color,
        output vram_rd_data,
        input  disp_rd_ready, disp_rd_valid, disp_rd_data,
        input  draw_ready,
        input  clear_busy, clear_done,
        input  vram_addr, vram_wr_ena, vram_wr_data,
        input  grant_src
    );

endinterface

`default_nettype wire

// File: rtl/vram_clear_engine.sv
// ============================================================================
// Module      : vram_clear_engine
// Description : Full-screen fill engine: colour latch, sequential address
//               counter, busy/done status and a permanent write request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_clear_engine
    import vram_arbiter_pkg::*;
#(
    parameter int VRAM_L = VRAM_L_DEF,
    parameter int N_ADDR = $clog2(VRAM_L)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              clear_start,
    input  wire pixel_t            clear_color,
    input  wire logic              wr_grant,
    output logic                   wr_req,
    output logic [N_ADDR-1:0]      clear_addr,
    output pixel_t                 clear_wr_data,
    output logic                   clear_busy,
    output logic                   clear_done
);

    localparam logic [0:0]        S_NORMAL   = 1'b0;
    localparam logic [0:0]        S_CLEARING = 1'b1;
    localparam logic [N_ADDR-1:0] LAST_ADDR  = N_ADDR'(VRAM_L - 1);

    logic [0:0]        state_q, state_d;
    logic [N_ADDR-1:0] clear_addr_q, clear_addr_d;
    pixel_t            color_q, color_d;
    logic              done_q, done_d;

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        color_d      = color_q;
        done_d       = 1'b0;
        case (state_q)
            S_NORMAL: begin
                // A start pulse while already clearing never reaches here,
                // so the latched colour cannot be overwritten mid-fill.
                if (clear_start) begin
                    color_d      = clear_color;
                    clear_addr_d = '0;
                    state_d      = S_CLEARING;
                end
            end
            S_CLEARING: begin
                if (wr_grant) begin
                    if (clear_addr_q == LAST_ADDR) begin
                        state_d      = S_NORMAL;
                        clear_addr_d = '0;
                        done_d       = 1'b1;
                    end else begin
                        clear_addr_d = clear_addr_q + 1'b1;
                    end
                end
            end
            default: state_d = S_NORMAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_NORMAL;
            clear_addr_q <= '0;
            color_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            color_q      <= color_d;
            done_q       <= done_d;
        end
    end

    assign clear_busy    = (state_q == S_CLEARING);
    assign wr_req        = clear_busy;
    assign clear_addr    = clear_addr_q;
    assign clear_wr_data = color_q;
    assign clear_done    = done_q;

    a_addr_bounded: assert property (@(posedge clk) disable iff (rst)
        clear_addr_q <= LAST_ADDR);

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
// Module      : vram_arbiter
// Description : One-access-per-clock arbiter for the single-port video RAM;
//               display reads win unless a pending write has been starved.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = DISPLAY_WIDTH_DEF,
    parameter int DISPLAY_HEIGHT = DISPLAY_HEIGHT_DEF,
    parameter int VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    parameter int STARVE_LIMIT   = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    vram_arbiter_if.slave bus
);

    localparam int                  N_ADDR     = $clog2(VRAM_L);
    localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [31:0]         VRAM_WORDS = 32'(VRAM_L);

    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                disp_rd_valid_q, disp_rd_valid_d;

    logic                w_clearing;
    logic [N_ADDR-1:0]   w_clear_addr;
    pixel_t              w_clear_data;
    logic                w_clear_busy;
    logic                w_clear_done;
    logic                w_write_pending;
    logic                w_starved;
    logic                w_wr_grant;
    logic                w_rd_grant;
    logic                w_idle;
    logic                w_draw_in_range;

    vram_clear_engine #(
        .VRAM_L (VRAM_L),
        .N_ADDR (N_ADDR)
    ) u_clear (
        .clk           (clk),
        .rst           (rst),
        .clear_start   (bus.clear_start),
        .clear_color   (bus.clear_color),
        .wr_grant      (w_wr_grant),
        .wr_req        (w_clearing),
        .clear_addr    (w_clear_addr),
        .clear_wr_data (w_clear_data),
        .clear_busy    (w_clear_busy),
        .clear_done    (w_clear_done)
    );

    // Grants are gated by rst so the RAM port stays quiet while the
    // asynchronous reset is held, not just after the next edge.
    always_comb begin
        w_write_pending = w_clearing | bus.draw_valid;
        w_starved       = (starve_cnt_q == STARVE_MAX);
        w_wr_grant      = !rst && w_write_pending && (w_starved || !bus.disp_rd_req);
        w_rd_grant      = !rst && !w_wr_grant && bus.disp_rd_req;
        w_idle          = !w_wr_grant && !w_rd_grant;
        w_draw_in_range = addr_in_range(32'(bus.draw_addr), VRAM_WORDS);
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!w_write_pending || w_wr_grant) begin
            starve_cnt_d = '0;
        end else if (w_rd_grant && !w_starved) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
        disp_rd_valid_d = w_rd_grant;
    end

    always_comb begin
        bus.vram_addr     = bus.disp_rd_addr;
        bus.vram_wr_ena   = 1'b0;
        bus.vram_wr_data  = bus.draw_data;
        bus.draw_ready    = 1'b0;
        bus.disp_rd_ready = w_rd_grant;
        bus.grant_src     = SRC_NONE;
        if (w_wr_grant) begin
            if (w_clearing) begin
                bus.vram_addr    = w_clear_addr;
                bus.vram_wr_data = w_clear_data;
                bus.vram_wr_ena  = 1'b1;
                bus.grant_src    = SRC_CLEAR;
            end else begin
                // Out-of-range draws are acknowledged so the drawer never
                // stalls, but never reach the RAM.
                bus.vram_addr    = bus.draw_addr;
                bus.vram_wr_data = bus.draw_data;
                bus.vram_wr_ena  = w_draw_in_range;
                bus.draw_ready   = 1'b1;
                bus.grant_src    = SRC_DRAW;
            end
        end else if (w_rd_grant) begin
            bus.grant_src = SRC_DISP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q    <= '0;
            disp_rd_valid_q <= 1'b0;
        end else begin
            starve_cnt_q    <= starve_cnt_d;
            disp_rd_valid_q <= disp_rd_valid_d;
        end
    end

    assign bus.disp_rd_valid = disp_rd_valid_q;
    assign bus.disp_rd_data  = bus.vram_rd_data;
    assign bus.clear_busy    = w_clear_busy;
    assign bus.clear_done    = w_clear_done;

    a_one_grant: assert property (@(posedge clk) disable iff (rst)
        $onehot({w_rd_grant, w_wr_grant, w_idle}));

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module      : tb_vram_arbiter
// Description : Directed vector table plus fill/reset sequences for the VRAM
//               arbiter on a reduced 10x4 screen with a behavioural RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;
    import vram_arbiter_pkg::*;

    localparam int DW = 10;
    localparam int DH = 4;
    localparam int VL = DW * DH;
    localparam int NA = $clog2(VL);
    localparam int SL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vram_arbiter_if #(.N_ADDR(NA)) bus();

    vram_arbiter #(
        .DISPLAY_WIDTH  (DW),
        .DISPLAY_HEIGHT (DH),
        .STARVE_LIMIT   (SL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural single-port RAM, one-cycle read latency, preloaded A000+i.
    logic [15:0] ram [VL];
    logic        preloaded = 1'b0;
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < VL; i++) ram[i] <= 16'(32'hA000 + i);
            preloaded <= 1'b1;
        end else if (bus.vram_wr_ena) begin
            ram[bus.vram_addr] <= bus.vram_wr_data;
        end
        bus.vram_rd_data <= ram[bus.vram_addr];
    end

    typedef struct {
        logic          rq;
        logic [NA-1:0] ra;
        logic          dv;
        logic [NA-1:0] da;
        logic [15:0]   dd;
        logic          e_rdy;
        logic          e_drdy;
        logic          e_wen;
        logic [NA-1:0] e_addr;
        logic          e_val;
        logic [15:0]   e_data;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input int rq, input int ra, input int dv, input int da,
                                input int dd, input int rdy, input int drdy, input int wen,
                                input int ad, input int val, input int dat);
        vec_t v;
        v.rq = rq[0];  v.ra = NA'(ra);  v.dv = dv[0];  v.da = NA'(da);  v.dd = 16'(dd);
        v.e_rdy = rdy[0];  v.e_drdy = drdy[0];  v.e_wen = wen[0];
        v.e_addr = NA'(ad);  v.e_val = val[0];  v.e_data = 16'(dat);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int   busy_cycles, bad, exp_addr, done_cnt, done_at, ram_bad, writes, found;
    src_e exp_src;

    initial begin
        bus.disp_rd_req  = 1'b0;  bus.disp_rd_addr = '0;
        bus.draw_valid   = 1'b0;  bus.draw_addr    = '0;  bus.draw_data = '0;
        bus.clear_start  = 1'b0;  bus.clear_color  = '0;

        // Reads 0..9, then starvation, idle/out-of-range writes, counter clear.
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1, i, 0, 0, 0, 1, 0, 0, i, (i > 0) ? 1 : 0, 'hA000 + i - 1));
        vecs.push_back(mk(1, 20, 1, 30, 'hF800, 1, 0, 0, 20, 1, 'hA009));
        vecs.push_back(mk(1, 21, 1, 30, 'hF800, 1, 0, 0, 21, 1, 'hA014));
        vecs.push_back(mk(1, 22, 1, 30, 'hF800, 1, 0, 0, 22, 1, 'hA015));
        vecs.push_back(mk(1, 23, 1, 30, 'hF800, 1, 0, 0, 23, 1, 'hA016));
        vecs.push_back(mk(1, 24, 1, 30, 'hF800, 0, 1, 1, 30, 1, 'hA017));
        vecs.push_back(mk(1, 24, 0, 0,  0,      1, 0, 0, 24, 0, 0));
        vecs.push_back(mk(1, 30, 0, 0,  0,      1, 0, 0, 30, 1, 'hA018));
        vecs.push_back(mk(0, 5,  0, 0,  0,      0, 0, 0, 5,  1, 'hF800));
        vecs.push_back(mk(0, 5,  1, 7,  'h1234, 0, 1, 1, 7,  0, 0));
        vecs.push_back(mk(0, 5,  1, 40, 'hFFFF, 0, 1, 0, 40, 0, 0));
        vecs.push_back(mk(0, 5,  1, 63, 'hFFFF, 0, 1, 0, 63, 0, 0));
        vecs.push_back(mk(1, 7,  0, 0,  0,      1, 0, 0, 7,  0, 0));
        vecs.push_back(mk(0, 6,  0, 0,  0,      0, 0, 0, 6,  1, 'h1234));
        vecs.push_back(mk(1, 1,  1, 2,  'hBEEF, 1, 0, 0, 1,  0, 0));
        vecs.push_back(mk(1, 1,  1, 2,  'hBEEF, 1, 0, 0, 1,  1, 'hA001));
        vecs.push_back(mk(1, 1,  0, 2,  'hBEEF, 1, 0, 0, 1,  1, 'hA001));
        for (int i = 0; i < SL; i++)
            vecs.push_back(mk(1, 1, 1, 2, 'hBEEF, 1, 0, 0, 1, 1, 'hA001));
        vecs.push_back(mk(1, 1,  1, 2,  'hBEEF, 0, 1, 1, 2,  1, 'hA001));
        vecs.push_back(mk(1, 2,  0, 0,  0,      1, 0, 0, 2,  0, 0));
        vecs.push_back(mk(0, 0,  0, 0,  0,      0, 0, 0, 0,  1, 'hBEEF));

        // Reset state with requests present.
        repeat (2) @(posedge clk);
        bus.disp_rd_req = 1'b1;
        bus.draw_valid  = 1'b1;
        #4;
        chk("rst_disp_rd_ready", bus.disp_rd_ready, 0);
        chk("rst_draw_ready",    bus.draw_ready,    0);
        chk("rst_vram_wr_ena",   bus.vram_wr_ena,   0);
        chk("rst_disp_rd_valid", bus.disp_rd_valid, 0);
        chk("rst_clear_busy",    bus.clear_busy,    0);
        chk("rst_clear_done",    bus.clear_done,    0);
        rst = 1'b0;
        bus.disp_rd_req = 1'b0;
        bus.draw_valid  = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk); #1;
            bus.disp_rd_req  = vecs[k].rq;
            bus.disp_rd_addr = vecs[k].ra;
            bus.draw_valid   = vecs[k].dv;
            bus.draw_addr    = vecs[k].da;
            bus.draw_data    = vecs[k].dd;
            #3;
            chk($sformatf("v%0d_disp_rd_ready", k), bus.disp_rd_ready, vecs[k].e_rdy);
            chk($sformatf("v%0d_draw_ready", k),    bus.draw_ready,    vecs[k].e_drdy);
            chk($sformatf("v%0d_vram_wr_ena", k),   bus.vram_wr_ena,   vecs[k].e_wen);
            chk($sformatf("v%0d_vram_addr", k),     bus.vram_addr,     vecs[k].e_addr);
            chk($sformatf("v%0d_disp_rd_valid", k), bus.disp_rd_valid, vecs[k].e_val);
            if (vecs[k].e_val)
                chk($sformatf("v%0d_disp_rd_data", k), bus.disp_rd_data, vecs[k].e_data);
            if (vecs[k].e_wen)
                chk($sformatf("v%0d_vram_wr_data", k), bus.vram_wr_data, vecs[k].dd);
            exp_src = vecs[k].e_rdy ? SRC_DISP : (vecs[k].e_drdy ? SRC_DRAW : SRC_NONE);
            chk($sformatf("v%0d_grant_src", k), 32'(bus.grant_src), 32'(exp_src));
        end

        // Fill with no display traffic; a draw in the start cycle still lands.
        @(posedge clk); #1;
        bus.disp_rd_req = 1'b0;
        bus.draw_valid  = 1'b1;  bus.draw_addr = NA'(3);  bus.draw_data = 16'h7777;
        bus.clear_start = 1'b1;  bus.clear_color = 16'h001F;
        #3;
        chk("clr_start_draw_ready", bus.draw_ready,  1);
        chk("clr_start_draw_wen",   bus.vram_wr_ena, 1);
        chk("clr_start_busy",       bus.clear_busy,  0);
        @(posedge clk); #1;
        bus.clear_start = 1'b0;  bus.clear_color = 16'hFFFF;
        bus.draw_addr = NA'(5);  bus.draw_data = 16'h5555;
        busy_cycles = 0; bad = 0; exp_addr = 0; done_cnt = 0; done_at = -1; ram_bad = 0;
        for (int c = 0; c < VL + 8; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            #3;
            if (bus.clear_busy) begin
                busy_cycles++;
                if (bus.draw_ready) bad++;
                if (!(bus.vram_wr_ena && bus.vram_addr == NA'(exp_addr) &&
                      bus.vram_wr_data == 16'h001F)) bad++;
                exp_addr++;
            end
            if (bus.clear_done) begin
                done_cnt++;
                done_at = c;
                for (int i = 0; i < VL; i++) if (ram[i] !== 16'h001F) ram_bad++;
            end
        end
        bus.draw_valid = 1'b0;
        chk("clr_busy_cycles", busy_cycles, VL);
        chk("clr_write_errors", bad, 0);
        chk("clr_done_count", done_cnt, 1);
        chk("clr_done_cycle", done_at, VL);
        chk("clr_ram_words_wrong", ram_bad, 0);

        // Fill interleaved with continuous reads; a mid-fill start is ignored.
        @(posedge clk); #1;
        bus.disp_rd_req = 1'b1;  bus.disp_rd_addr = NA'(9);
        bus.clear_start = 1'b1;  bus.clear_color = 16'h07E0;
        @(posedge clk); #1;
        bus.clear_start = 1'b0;  bus.clear_color = 16'h0F0F;
        busy_cycles = 0; bad = 0; exp_addr = 0; done_cnt = 0; done_at = -1; writes = 0;
        for (int c = 0; c < 5 * VL + 10; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                bus.clear_start = (c == 50);
            end
            #3;
            if (bus.clear_busy) busy_cycles++;
            if (bus.vram_wr_ena) begin
                writes++;
                if (!(bus.vram_addr == NA'(exp_addr) && bus.vram_wr_data == 16'h07E0)) bad++;
                exp_addr++;
            end
            if (bus.clear_done) begin
                done_cnt++;
                done_at = c;
            end
        end
        bus.clear_start = 1'b0;
        chk("ilv_busy_cycles", busy_cycles, 5 * VL);
        chk("ilv_write_count", writes, VL);
        chk("ilv_write_errors", bad, 0);
        chk("ilv_done_count", done_cnt, 1);
        chk("ilv_done_cycle", done_at, 5 * VL);

        // Asynchronous reset in the middle of an interleaved fill.
        @(posedge clk); #1;
        bus.clear_start = 1'b1;  bus.clear_color = 16'h1111;
        @(posedge clk); #1;
        bus.clear_start = 1'b0;
        found = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #4;
            if (bus.vram_wr_ena && bus.vram_addr == NA'(20)) begin
                found = 1;
                break;
            end
        end
        chk("arst_reached_addr20", found, 1);
        @(posedge clk); #4;
        @(posedge clk); #4;
        chk("arst_pre_valid", bus.disp_rd_valid, 1);
        chk("arst_pre_busy",  bus.clear_busy,    1);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy_drop",  bus.clear_busy,    0);
        chk("arst_valid_drop", bus.disp_rd_valid, 0);
        chk("arst_wr_ena",     bus.vram_wr_ena,   0);
        chk("arst_rd_ready",   bus.disp_rd_ready, 0);
        done_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #4;
            if (bus.clear_done) done_cnt++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.disp_rd_req = 1'b0;
        #3;
        if (bus.clear_done) done_cnt++;
        chk("arst_no_done", done_cnt, 0);
        chk("arst_idle_after", bus.clear_busy, 0);
        @(posedge clk); #1;
        bus.clear_start = 1'b1;  bus.clear_color = 16'h2222;
        @(posedge clk); #1;
        bus.clear_start = 1'b0;
        #3;
        chk("restart_busy",    bus.clear_busy,   1);
        chk("restart_wr_ena",  bus.vram_wr_ena,  1);
        chk("restart_addr",    bus.vram_addr,    0);
        chk("restart_wr_data", bus.vram_wr_data, 16'h2222);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
